// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS data-memory controller slice:
//   - DATA_MEM_WIDTH : width of the core's data port (address and data)
//   - MMIO_BASE      : address bit pattern that selects the MMIO window
//   - OFS_*          : byte offsets of the MMIO registers inside the window
//   - STAT_*         : bit positions of the fields in the STATUS register
//   - mmio_reg_e     : decoded MMIO register selector
//   - decodeMmio()   : maps a byte address onto an MMIO register selector
package mips_pkg;

  localparam int DATA_MEM_WIDTH = 32;

  localparam logic [31:0] MMIO_BASE    = 32'h8000_0000;
  localparam logic [31:0] OFS_OUT_DATA = 32'h0000_0000;
  localparam logic [31:0] OFS_STATUS   = 32'h0000_0004;
  localparam logic [31:0] OFS_CYCLE    = 32'h0000_0008;

  localparam int STAT_OVF_BIT   = 8;
  localparam int STAT_FULL_BIT  = 7;
  localparam int STAT_EMPTY_BIT = 6;
  localparam int STAT_CNT_W     = 5;

  typedef enum logic [1:0] {
    REG_OUT_DATA,
    REG_STATUS,
    REG_CYCLE,
    REG_NONE
  } mmio_reg_e;

  // The window-select bit and the byte lane bits are stripped so that only
  // the word offset inside the MMIO window takes part in the decode.
  function automatic mmio_reg_e decodeMmio(input logic [31:0] addr);
    logic [31:0] ofs;
    ofs = addr & ~MMIO_BASE & ~32'h0000_0003;
    case (ofs)
      OFS_OUT_DATA: return REG_OUT_DATA;
      OFS_STATUS:   return REG_STATUS;
      OFS_CYCLE:    return REG_CYCLE;
      default:      return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mips_mmio_fifo.sv
// mips_mmio_fifo
// Output FIFO behind the OUT_DATA MMIO register.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_push       : write request carrying i_data
//   i_pop        : consumer request to remove the head entry
//   i_clrOvf     : clears the sticky overflow flag (wins over a same-cycle set)
//   i_data       : word to push
//   o_data       : head entry (meaningful only while o_empty=0)
//   o_full       : FIFO holds DEPTH entries
//   o_empty      : FIFO holds no entries
//   o_count      : number of entries, 0..DEPTH
//   o_overflow   : sticky flag, set when a push was dropped
module mips_mmio_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_clrOvf,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_popOk;
  logic w_pushOk;
  logic w_drop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when it coincides with a pop.
  assign w_popOk  = i_pop & ~o_empty;
  assign w_pushOk = i_push & (~o_full | w_popOk);
  assign w_drop   = i_push & ~w_pushOk;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_popOk)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_pushOk, w_popOk})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow <= (r_overflow | w_drop) & ~i_clrOvf;
    end
  end

  // Storage is not reset; stale words are never visible while empty.
  always_ff @(posedge clk) begin
    if (w_pushOk) r_mem[r_wrPtr] <= i_data;
  end

  assign o_data     = r_mem[r_rdPtr];
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/mips_dmem_ctrl.sv
// mips_dmem_ctrl
// Data-memory controller for a single-cycle MIPS core: a word RAM with
// combinational reads, plus an MMIO window (address bit 31 set) holding an
// output FIFO (OUT_DATA), its STATUS register and a free-running CYCLE counter.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   memwrite   : store strobe from the core
//   memaddr    : byte address (bits [1:0] ignored)
//   writedata  : store data
//   readdata   : load data, combinational on memaddr
//   out_valid  : output FIFO not empty
//   out_data   : FIFO head word
//   out_ready  : consumer accepts the head word
// Configuration:
//   MIPS_DMEM_CYCLE_CNT_EN : when defined the CYCLE counter is built; when not,
//                            CYCLE reads 0 and writes to it are ignored.
module mips_dmem_ctrl
  import mips_pkg::*;
#(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      memwrite,
  input  logic [DATA_MEM_WIDTH-1:0] memaddr,
  input  logic [DATA_MEM_WIDTH-1:0] writedata,
  output logic [DATA_MEM_WIDTH-1:0] readdata,
  output logic                      out_valid,
  output logic [DATA_MEM_WIDTH-1:0] out_data,
  input  logic                      out_ready
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_MEM_WIDTH-1:0] r_ram [RAM_WORDS];

  logic                      w_isMmio;
  mmio_reg_e                 w_reg;
  logic [RAM_AW-1:0]         w_ramIdx;
  logic                      w_ramWr;
  logic                      w_fifoPush;
  logic                      w_statusWr;
  logic                      w_fifoFull;
  logic                      w_fifoEmpty;
  logic [CNT_W-1:0]          w_fifoCount;
  logic                      w_fifoOvf;
  logic [DATA_MEM_WIDTH-1:0] w_status;
  logic [DATA_MEM_WIDTH-1:0] w_cycle;

  assign w_isMmio   = |(memaddr & MMIO_BASE);
  assign w_reg      = decodeMmio(memaddr);
  // Address bits above the RAM index are dropped, so RAM accesses alias.
  assign w_ramIdx   = memaddr[RAM_AW+1:2];
  assign w_ramWr    = memwrite & ~w_isMmio;
  assign w_fifoPush = memwrite & w_isMmio & (w_reg == REG_OUT_DATA);
  assign w_statusWr = memwrite & w_isMmio & (w_reg == REG_STATUS);

  // Data RAM: write on the edge, so a same-cycle read still sees old data.
  always_ff @(posedge clk) begin
    if (w_ramWr) r_ram[w_ramIdx] <= writedata;
  end

  mips_mmio_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_MEM_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_fifoPush),
    .i_pop      (out_ready),
    .i_clrOvf   (w_statusWr),
    .i_data     (writedata),
    .o_data     (out_data),
    .o_full     (w_fifoFull),
    .o_empty    (w_fifoEmpty),
    .o_count    (w_fifoCount),
    .o_overflow (w_fifoOvf)
  );

  assign out_valid = ~w_fifoEmpty;

`ifdef MIPS_DMEM_CYCLE_CNT_EN
  logic                      w_cycleClr;
  logic [DATA_MEM_WIDTH-1:0] r_cycle;

  assign w_cycleClr = memwrite & w_isMmio & (w_reg == REG_CYCLE);

  // A software clear takes priority over the free-running increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle <= '0;
    end else if (w_cycleClr) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
    end
  end

  assign w_cycle = r_cycle;
`else
  assign w_cycle = '0;
`endif

  // STATUS layout: {overflow, full, empty, 0, count}
  always_comb begin
    w_status                 = '0;
    w_status[STAT_CNT_W-1:0] = STAT_CNT_W'(w_fifoCount);
    w_status[STAT_EMPTY_BIT] = w_fifoEmpty;
    w_status[STAT_FULL_BIT]  = w_fifoFull;
    w_status[STAT_OVF_BIT]   = w_fifoOvf;
  end

  // Load path: RAM when bit 31 is clear, otherwise the MMIO register file.
  always_comb begin
    readdata = '0;
    if (!w_isMmio) begin
      readdata = r_ram[w_ramIdx];
    end else begin
      case (w_reg)
        REG_STATUS: readdata = w_status;
        REG_CYCLE:  readdata = w_cycle;
        default:    readdata = '0;
      endcase
    end
  end

endmodule

// File: doc/mips_dmem_ctrl.md
MIPS_DMEM_CTRL -- requirements
Module: mips_dmem_ctrl

Interface
REQ-001: Parameter RAM_WORDS, default 256, number of 32-bit words in the data RAM; power of two.
REQ-002: Parameter FIFO_DEPTH, default 4, output FIFO entries; power of two, minimum 2.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: memwrite  input  1  write strobe from the core's data port.
REQ-006: memaddr  input  DATA_MEM_WIDTH  byte address from the core.
REQ-007: writedata  input  DATA_MEM_WIDTH  store data from the core.
REQ-008: readdata  output  DATA_MEM_WIDTH  load data returned to the core.
REQ-009: out_valid  output  1  output FIFO holds at least one word.
REQ-010: out_data  output  DATA_MEM_WIDTH  FIFO head word; valid when out_valid=1.
REQ-011: out_ready  input  1  downstream consumer accepts the head word.

Function
REQ-012: memaddr[31]=0 selects RAM; memaddr[31]=1 selects MMIO; memaddr[1:0] ignored everywhere.
REQ-013: RAM index = memaddr[log2(RAM_WORDS)+1:2]; higher bits ignored, so addresses wrap modulo RAM size.
REQ-014: Reads are combinational, zero latency: readdata reflects the current memaddr in the same cycle.
REQ-015: RAM writes occur on the clk edge when memwrite=1; a same-cycle read returns old data, the next cycle returns new data.
REQ-016: MMIO OUT_DATA (offset 0x0): write pushes writedata into the FIFO; read returns 0.
REQ-017: MMIO STATUS (offset 0x4): read returns {overflow[8], full[7], empty[6], 0, count[4:0]}; any write clears overflow.
REQ-018: MMIO CYCLE (offset 0x8): read returns the 32-bit cycle counter; any write loads 0.
REQ-019: Other MMIO offsets read 0; writes to them are ignored.
REQ-020: Cycle counter increments by 1 each cycle and wraps 0xFFFF_FFFF->0; a write-clear wins over the increment.
REQ-021: Pop occurs when out_valid=1 and out_ready=1; out_data then advances to the next entry on the following cycle.
REQ-022: Push to a non-full FIFO is accepted; push to a full FIFO with no same-cycle pop is dropped and sets sticky overflow.
REQ-023: Push and pop in the same cycle while full are both accepted; count is unchanged and overflow is not set.
REQ-024: Push while empty: out_valid rises the next cycle; no same-cycle bypass.
REQ-025: Read/write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-026: An overflow set and a STATUS-write clear in the same cycle results in overflow=0.

Reset
REQ-027: rst clears FIFO pointers, count, overflow and the cycle counter to 0 and drives out_valid=0, independent of clk.
REQ-028: RAM contents are not reset.
REQ-029: During reset, readdata returns RAM contents or the reset MMIO values; out_data is don't-care.
REQ-030: Reset mid-transfer discards all FIFO entries; no pop is reported.

Configuration
REQ-031: Macro MIPS_DMEM_CYCLE_CNT_EN: when defined, the cycle counter per REQ-018/020 is compiled in.
REQ-032: Without the macro, no counter flops exist, CYCLE reads 0, and writes to CYCLE are ignored.

Structure
REQ-033: mips_pkg holds MMIO_BASE (0x8000_0000), offsets OUT_DATA/STATUS/CYCLE, and the STATUS bit positions.
REQ-034: The FIFO is sub-module mips_mmio_fifo (push, pop, data, full, empty, count, overflow); the RAM and decode logic stay in the top module.

Verification
REQ-035: Write 0xDEADBEEF @0x10, read @0x10 next cycle -> readdata=0xDEADBEEF; read @0x10+4*RAM_WORDS -> same value (wrap).
REQ-036: Push 1,2,3,4 with out_ready=0 -> STATUS count=4, full=1; 5th push -> overflow=1, FIFO holds 1..4 unchanged.
REQ-037: Full FIFO, push 5 with out_ready=1 in the same cycle -> out_data 1 accepted, count stays 4, overflow=0; drain order is 2,3,4,5.
REQ-038: Assert rst mid-drain with count=3 -> out_valid=0 and count=0 immediately; overflow=0.
REQ-039: With the macro defined, write CYCLE then read 10 cycles later -> 10; without the macro -> 0.
REQ-040: Read unmapped offset 0xC -> 0; misaligned write @0x13 -> lands in the word at 0x10.
